pll_phase_ctrl: RTL
===================

// Module: pll_phase_ctrl
// PURPOSE
//  Runtime supervisor for a GTP_PLL_E3 instance: holds the PLL in reset, qualifies LOCK, and re-locks automatically on lock loss.
//  Executes dynamic phase-shift requests (channel, direction, step count) on up to five PLL outputs via PHASE_SEL/PHASE_DIR/PHASE_STEP_N.
//  Tracks the signed fine-phase offset of each channel. Sits beside the PLL wrapper and serves the capture/DDR clocking logic.
// PARAMETERS
//  N_CH          5      number of phase-adjustable outputs (1..5)
//  STEP_W        8      width of req_steps (max 255 steps per request)
//  OFS_W         12     width of per-channel signed offset counter
//  STEP_LOW      2      cycles phase_step_n is held low per step (>=1)
//  STEP_GAP      4      cycles phase_step_n is held high between steps (>=1)
//  RST_CYCLES    16     cycles pll_rst_o is asserted per reset attempt
//  LOCK_FILT     8      consecutive synced-high lock cycles before locked_o rises
//  LOCK_TIMEOUT  65536  cycles in WAIT_LOCK before a retry reset
// PORTS
//  clk           in   1              system clock (free-running, not from this PLL)
//  rst           in   1              asynchronous active-high reset
//  pll_lock_i    in   1              raw PLL LOCK (asynchronous to clk)
//  pll_rst_o     out  1              to PLL RST
//  locked_o      out  1              filtered lock status
//  relock_cnt    out  8              count of reset attempts after the first, saturating at 255
//  req_valid     in   1              phase-shift request valid
//  req_ready     out  1              request accepted when valid & ready
//  req_ch        in   3              target output index
//  req_dir       in   1              1 = advance (+1 per step), 0 = retard (-1)
//  req_steps     in   STEP_W         number of steps
//  done_o        out  1              1-cycle pulse: request finished
//  err_o         out  1              1-cycle pulse: request rejected or aborted
//  phase_sel     out  3              to PLL PHASE_SEL
//  phase_dir     out  1              to PLL PHASE_DIR
//  phase_step_n  out  1              to PLL PHASE_STEP_N, active low
//  ch_offset     out  N_CH*OFS_W     per-channel signed offset; channel k occupies [k*OFS_W +: OFS_W]
// BEHAVIOUR
//  Reset: pll_rst_o=1, state=RESET_PLL, locked_o=0, req_ready=0, done_o=0, err_o=0, phase_step_n=1,
//   phase_sel=0, phase_dir=0, offsets=0, relock_cnt=0.
//  Lock qualification: pll_lock_i passes through a 2-FF synchroniser.
//   - locked_o rises after LOCK_FILT consecutive synced-high cycles.
//   - locked_o falls in the cycle after a synced low is seen.
//  FSM:
//   RESET_PLL: pll_rst_o=1 for RST_CYCLES cycles -> WAIT_LOCK.
//   WAIT_LOCK: pll_rst_o=0.
//    - locked_o=1 -> IDLE.
//    - LOCK_TIMEOUT cycles elapse -> RESET_PLL, relock_cnt++ (saturating at 255).
//   IDLE: req_ready=1. On req_valid, latch ch/dir/steps. Then:
//    - req_ch>=N_CH: err_o pulse next cycle, stay IDLE.
//    - req_steps==0: done_o pulse next cycle, stay IDLE.
//    - otherwise -> SETUP.
//   SETUP (1 cycle): drive phase_sel and phase_dir. These stay stable until return to IDLE. -> STEP_LO.
//   STEP_LO: phase_step_n=0 for STEP_LOW cycles. On exit, the channel offset changes by +/-1
//    (two's-complement wrap modulo 2^OFS_W) and the remaining-step count decrements. -> STEP_HI.
//   STEP_HI: phase_step_n=1 for STEP_GAP cycles.
//    - remaining-step count>0 -> STEP_LO.
//    - otherwise done_o pulse and -> IDLE.
//  req_ready is 0 in every state except IDLE. A held req_valid is taken in IDLE only.
//  Lock loss (locked_o falls) in IDLE/SETUP/STEP_*: next state is RESET_PLL.
//   - phase_step_n forced to 1; all offsets cleared (PLL returns to its static phase).
//   - err_o pulses if a request was in flight; relock_cnt++.
//  Request latency: accept -> first phase_step_n low = 2 cycles.
//   Total duration = 2 + steps*(STEP_LOW+STEP_GAP) cycles, then done_o.
//  rst asserted mid-operation: immediate return to the reset values above. The request in flight is dropped with no done_o/err_o.
// STRUCTURE
//  pll_ctrl_pkg:
//   - state enum {RESET_PLL, WAIT_LOCK, IDLE, SETUP, STEP_LO, STEP_HI}
//   - max-channel constant (5)
//   - phase_sel width (3)
//  Sub-module pll_lock_filter: 2-FF synchroniser + LOCK_FILT counter, output locked_o.
//  The FSM, step/gap timers and offset registers live in pll_phase_ctrl.
// TESTING
//  1. Reset release, PLL model asserts lock 50 cycles after pll_rst_o falls:
//     pll_rst_o high 16 cycles; locked_o rises 2+8 cycles after lock; req_ready=1.
//  2. req ch=2 dir=1 steps=3:
//     phase_sel=2; three low pulses of 2 cycles, gap 4; done_o at cycle 20 after accept; ch_offset[2]=+3.
//  3. req ch=2 dir=0 steps=5 after test 2:
//     ch_offset[2]=-2; a held req_valid is not accepted until done_o.
//  4. req ch=6, then req steps=0:
//     err_o pulse with no step pulses, then done_o pulse with no step pulses; offsets unchanged.
//  5. Drop pll_lock_i during step 2 of a 4-step request:
//     err_o pulses; phase_step_n=1; pll_rst_o reasserted; offsets=0; relock_cnt=1.
//  6. Lock never asserts:
//     RESET_PLL/WAIT_LOCK cycle every 16+65536 cycles; relock_cnt increments and saturates at 255.

Source files
------------

// File: rtl/pll_ctrl_pkg.sv
// Shared constants, state codes and helpers for the PLL runtime supervisor.
package pll_ctrl_pkg;

  localparam int MAX_CH = 5;
  localparam int SEL_W  = 3;

  typedef logic [2:0] state_t;

  localparam state_t ST_RESET_PLL = 3'd0;
  localparam state_t ST_WAIT_LOCK = 3'd1;
  localparam state_t ST_IDLE      = 3'd2;
  localparam state_t ST_SETUP     = 3'd3;
  localparam state_t ST_STEP_LO   = 3'd4;
  localparam state_t ST_STEP_HI   = 3'd5;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/pll_lock_filter.sv
// Synchronises the raw PLL LOCK and qualifies it over LOCK_FILT consecutive high cycles.
module pll_lock_filter #(
  parameter int LOCK_FILT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic lock_raw,
  output logic locked
);

  localparam int CNT_W = (LOCK_FILT < 2) ? 1 : $clog2(LOCK_FILT + 1);

  logic             sync1_r;
  logic             sync2_r;
  logic [CNT_W-1:0] cnt_r;
  logic             locked_r;

  // Two-flop synchroniser followed by a run-length qualifier; any synced low drops lock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r  <= 1'b0;
      sync2_r  <= 1'b0;
      cnt_r    <= {CNT_W{1'b0}};
      locked_r <= 1'b0;
    end else begin
      sync1_r <= lock_raw;
      sync2_r <= sync1_r;
      if (!sync2_r) begin
        cnt_r    <= {CNT_W{1'b0}};
        locked_r <= 1'b0;
      end else if (cnt_r == CNT_W'(LOCK_FILT - 1)) begin
        locked_r <= 1'b1;
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

  assign locked = locked_r;

endmodule

// File: rtl/pll_phase_ctrl.sv
// PLL supervisor: reset/relock sequencing plus dynamic phase-step execution with
// per-channel signed offset tracking.
module pll_phase_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int N_CH         = MAX_CH,
  parameter int STEP_W       = 8,
  parameter int OFS_W        = 12,
  parameter int STEP_LOW     = 2,
  parameter int STEP_GAP     = 4,
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_FILT    = 8,
  parameter int LOCK_TIMEOUT = 65536
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pll_lock_i,
  output logic                  pll_rst_o,
  output logic                  locked_o,
  output logic [7:0]            relock_cnt,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [SEL_W-1:0]      req_ch,
  input  logic                  req_dir,
  input  logic [STEP_W-1:0]     req_steps,
  output logic                  done_o,
  output logic                  err_o,
  output logic [SEL_W-1:0]      phase_sel,
  output logic                  phase_dir,
  output logic                  phase_step_n,
  output logic [N_CH*OFS_W-1:0] ch_offset
);

  localparam int T_A    = (LOCK_TIMEOUT > RST_CYCLES) ? LOCK_TIMEOUT : RST_CYCLES;
  localparam int T_B    = (STEP_LOW > STEP_GAP) ? STEP_LOW : STEP_GAP;
  localparam int TMR_W  = $clog2(((T_A > T_B) ? T_A : T_B) + 1);
  localparam logic [SEL_W-1:0] N_CH_L = SEL_W'(N_CH);

  state_t            state_r;
  logic [TMR_W-1:0]  tmr_r;
  logic [STEP_W-1:0] rem_r;
  logic [SEL_W-1:0]  sel_r;
  logic              dir_r;
  logic              step_n_r;
  logic              pll_rst_r;
  logic [7:0]        relock_r;
  logic              done_r;
  logic              err_r;
  logic [OFS_W-1:0]  ofs_r [N_CH];
  logic              locked_s;
  logic              lock_lost_s;
  logic              in_flight_s;

  pll_lock_filter #(.LOCK_FILT(LOCK_FILT)) u_lock_filter (
    .clk      (clk),
    .rst      (rst),
    .lock_raw (pll_lock_i),
    .locked   (locked_s)
  );

  assign lock_lost_s = !locked_s && (state_r == ST_IDLE || state_r == ST_SETUP ||
                                     state_r == ST_STEP_LO || state_r == ST_STEP_HI);
  assign in_flight_s = (state_r != ST_IDLE);

  // Supervisor FSM with reset/lock/step timers and offset bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_RESET_PLL;
      tmr_r     <= {TMR_W{1'b0}};
      rem_r     <= {STEP_W{1'b0}};
      sel_r     <= {SEL_W{1'b0}};
      dir_r     <= 1'b0;
      step_n_r  <= 1'b1;
      pll_rst_r <= 1'b1;
      relock_r  <= 8'd0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
      for (int k = 0; k < N_CH; k++) ofs_r[k] <= {OFS_W{1'b0}};
    end else begin
      done_r <= 1'b0;
      err_r  <= 1'b0;
      if (lock_lost_s) begin
        // The PLL restarts at its static phase, so every tracked offset is void.
        state_r   <= ST_RESET_PLL;
        tmr_r     <= {TMR_W{1'b0}};
        pll_rst_r <= 1'b1;
        step_n_r  <= 1'b1;
        err_r     <= in_flight_s;
        relock_r  <= sat_inc8(relock_r);
        for (int k = 0; k < N_CH; k++) ofs_r[k] <= {OFS_W{1'b0}};
      end else begin
        case (state_r)
          ST_RESET_PLL: begin
            if (tmr_r == TMR_W'(RST_CYCLES - 1)) begin
              state_r   <= ST_WAIT_LOCK;
              tmr_r     <= {TMR_W{1'b0}};
              pll_rst_r <= 1'b0;
            end else begin
              tmr_r <= tmr_r + TMR_W'(1);
            end
          end
          ST_WAIT_LOCK: begin
            if (locked_s) begin
              state_r <= ST_IDLE;
              tmr_r   <= {TMR_W{1'b0}};
            end else if (tmr_r == TMR_W'(LOCK_TIMEOUT - 1)) begin
              state_r   <= ST_RESET_PLL;
              tmr_r     <= {TMR_W{1'b0}};
              pll_rst_r <= 1'b1;
              relock_r  <= sat_inc8(relock_r);
            end else begin
              tmr_r <= tmr_r + TMR_W'(1);
            end
          end
          ST_IDLE: begin
            if (req_valid) begin
              if (req_ch >= N_CH_L) begin
                err_r <= 1'b1;
              end else if (req_steps == {STEP_W{1'b0}}) begin
                done_r <= 1'b1;
              end else begin
                sel_r   <= req_ch;
                dir_r   <= req_dir;
                rem_r   <= req_steps;
                state_r <= ST_SETUP;
              end
            end
          end
          ST_SETUP: begin
            state_r  <= ST_STEP_LO;
            tmr_r    <= {TMR_W{1'b0}};
            step_n_r <= 1'b0;
          end
          ST_STEP_LO: begin
            if (tmr_r == TMR_W'(STEP_LOW - 1)) begin
              state_r  <= ST_STEP_HI;
              tmr_r    <= {TMR_W{1'b0}};
              step_n_r <= 1'b1;
              rem_r    <= rem_r - STEP_W'(1);
              for (int k = 0; k < N_CH; k++) begin
                if (sel_r == SEL_W'(k)) begin
                  ofs_r[k] <= dir_r ? ofs_r[k] + OFS_W'(1) : ofs_r[k] - OFS_W'(1);
                end
              end
            end else begin
              tmr_r <= tmr_r + TMR_W'(1);
            end
          end
          ST_STEP_HI: begin
            if (tmr_r == TMR_W'(STEP_GAP - 1)) begin
              tmr_r <= {TMR_W{1'b0}};
              if (rem_r != {STEP_W{1'b0}}) begin
                state_r  <= ST_STEP_LO;
                step_n_r <= 1'b0;
              end else begin
                state_r <= ST_IDLE;
                done_r  <= 1'b1;
              end
            end else begin
              tmr_r <= tmr_r + TMR_W'(1);
            end
          end
          default: begin
            state_r   <= ST_RESET_PLL;
            tmr_r     <= {TMR_W{1'b0}};
            pll_rst_r <= 1'b1;
            step_n_r  <= 1'b1;
          end
        endcase
      end
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ofs
    assign ch_offset[g*OFS_W +: OFS_W] = ofs_r[g];
  end

  assign req_ready    = (state_r == ST_IDLE) && locked_s;
  assign pll_rst_o    = pll_rst_r;
  assign locked_o     = locked_s;
  assign relock_cnt   = relock_r;
  assign done_o       = done_r;
  assign err_o        = err_r;
  assign phase_sel    = sel_r;
  assign phase_dir    = dir_r;
  assign phase_step_n = step_n_r;

endmodule
